base_shift_right_pipe: RTL and testbench
========================================

# base_shift_right_pipe

Pipelined, flow-controlled right shifter: the counterpart of the combinational left shifter in the base cell library. It takes a data word, a shift amount and a logical/arithmetic select through a valid/ready handshake. It resolves one shift-amount bit per register stage and delivers the result, plus a sticky flag of discarded bits, through a valid/ready handshake. It sits in datapaths where a full-width barrel shift does not close timing in one cycle, such as alignment, normalisation and field extraction.

## Interface
Parameters:
- width, 32, data width in bits; must be ≥ 2.
- swidth, $clog2(width), shift-amount width; also the pipeline depth.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_v  input  1  input valid.
- i_r  output  1  input ready; transfer occurs when i_v & i_r.
- i_samt  input  [0:swidth-1]  shift amount; bit 0 is the MSB.
- i_arith  input  1  1 = arithmetic (fill with i_d[0]), 0 = logical (fill with 0).
- i_d  input  [0:width-1]  data; bit 0 is the MSB, so a right shift moves bits toward higher indices.
- o_v  output  1  output valid.
- o_r  input  1  output ready; transfer occurs when o_v & o_r.
- o_d  output  [0:width-1]  shifted data.
- o_lost  output  1  OR of all bits shifted out past index width-1.

## Operation
- Result: o_d = i_d >> i_samt (logical) or >>> i_samt (arithmetic, sign = i_d[0]). Amounts ≥ width cannot occur, because swidth = $clog2(width). For non-power-of-2 width, amounts ≥ width give all-fill, and o_lost = OR of i_d.
- Stage k (0..swidth-1) registers: valid, data, remaining amount bits, arith, sign, lost.
- Stage k shifts by 2^(swidth-1-k) when its amount bit is set. Largest weight goes first, so stage 0 drops the most bits.
- Fill bits come from the captured sign (i_d[0] at input) when arith = 1, otherwise 0. The sign is captured once at entry and carried, not re-read from shifted data.
- lost(k) = lost(k-1) | OR of the bits discarded at stage k. lost enters as 0.
- Flow control per stage: the stage loads when its slot is empty or the downstream stage takes its contents in the same cycle.
  - ready(k) = ~valid(k) | ready(k+1).
  - ready(swidth) = o_r.
  - i_r = ready(0).
- The ready chain is combinational across stages. This is accepted; no skid buffers.
- A stalled stage holds data, amount, arith, sign and lost unchanged.
- o_v = valid(swidth-1). o_d and o_lost come directly from the last stage registers.
- Data in bubbles (valid = 0) is don't-care but must not corrupt held contents.

## Timing
- Latency: swidth cycles from an accepted input to o_v, with o_r held high.
- Throughput: 1 result/cycle while o_r = 1.
- Reset: all stage valids are cleared, so o_v = 0, o_d = 0 and o_lost = 0 on the cycle after reset. i_r = 1 on the first cycle after reset, because all stages are empty.
- Reset mid-operation: all in-flight items are dropped; none emerge afterwards.
- Reset dominates any simultaneous input transfer.
- Full pipe with o_r = 0: i_r = 0 and no state changes.
- The cycle o_r rises, every stage advances and i_r = 1 in that same cycle.
- Simultaneous output and input transfer on a full pipe is a normal advance, with no bubble inserted.
- Order is preserved; no reordering, duplication or loss under any o_r pattern.
- o_d and o_lost are stable while o_v & ~o_r.

## Structure
- Package base_shift_pkg: a stage payload struct (data, amount remainder, arith, sign, lost), parameterised through a width-agnostic pattern or localparam functions. It also holds a helper function that computes fill/discard masks.
- One sub-module: base_shift_right_stage (parameters width and shift weight), containing the per-stage register, shift mux, lost accumulation and ready computation.
- The top module instantiates swidth stages in a generate loop.

## Test plan
With width=8 and swidth=3:
- Logical: i_d=8'b1011_0110, i_samt=3, i_arith=0 → after 3 cycles o_d=8'b0001_0110, o_lost=1.
- Arithmetic: i_d=8'b1000_0000, i_samt=7, i_arith=1 → o_d=8'hFF, o_lost=0. The same input with i_arith=0 → o_d=8'h01.
- Zero shift: i_d=8'hA5, i_samt=0 → o_d=8'hA5, o_lost=0, latency 3.
- Backpressure: stream 10 random items while o_r toggles randomly. The outputs must match a reference model in order; i_r=0 exactly when all 3 stages are valid and o_r=0.
- Full throughput: i_v=1 and o_r=1 for 20 cycles → 20 results on consecutive cycles, starting 3 cycles after the first input.
- Reset mid-stream: load 3 items, assert reset with o_r=0, then release → o_v=0, i_r=1, and no stale item ever appears.

Source files
------------

// File: rtl/base_shift_pkg.sv
// Shared types and helpers for the pipelined right shifter.
package base_shift_pkg;

  // Upper bounds for the payload fields; a shifter instance uses the low
  // width/swidth bits and keeps the rest at zero.
  localparam int MAX_W  = 64;
  localparam int MAX_SW = 6;

  // Per-stage payload, data is little-endian in the low bits.
  typedef struct packed {
    logic [MAX_W-1:0]  data;
    logic [MAX_SW-1:0] amt;
    logic              arith;
    logic              sign;
    logic              lost;
  } stage_t;

  // Mask with the low n bits set: discard mask for a shift by n, and
  // (width mask & ~low_mask(width-n)) gives the fill mask for the top n bits.
  function automatic logic [MAX_W-1:0] low_mask(input int n);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/base_shift_right_pipe_if.sv
// Valid/ready request and response bundle of the pipelined right shifter.
interface base_shift_right_pipe_if #(
  parameter int width  = 32,
  parameter int swidth = $clog2(width)
);
  logic              i_v;
  logic              i_r;
  logic [0:swidth-1] i_samt;
  logic              i_arith;
  logic [0:width-1]  i_d;
  logic              o_v;
  logic              o_r;
  logic [0:width-1]  o_d;
  logic              o_lost;

  modport master (output i_v, i_samt, i_arith, i_d, o_r,
                  input  i_r, o_v, o_d, o_lost);
  modport slave  (input  i_v, i_samt, i_arith, i_d, o_r,
                  output i_r, o_v, o_d, o_lost);
endinterface

// File: rtl/base_shift_right_stage.sv
// One pipeline stage: conditional shift by a fixed weight, lost-bit
// accumulation, and a single-entry register slot with pass-through ready.
module base_shift_right_stage
  import base_shift_pkg::*;
#(
  parameter int width   = 32,
  parameter int weight  = 1,
  parameter int amt_bit = 0   // amount bit (little-endian) this stage resolves
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_v,
  output logic   in_r,
  input  stage_t in_p,
  output logic   out_v,
  input  logic   out_r,
  output stage_t out_p
);

  logic   v_q, v_d;
  stage_t p_q, p_d;
  stage_t shifted;

  // Slot accepts when empty or when its content leaves this cycle.
  assign in_r = ~v_q | out_r;

  // Shift mux: fill comes from the sign captured at entry, never from data.
  always_comb begin
    shifted = in_p;
    if (in_p.amt[amt_bit]) begin
      shifted.data = (in_p.data >> weight) |
                     ((in_p.arith & in_p.sign) ?
                      (low_mask(width) & ~low_mask(width - weight)) : '0);
      shifted.lost = in_p.lost | (|(in_p.data & low_mask(weight)));
    end
  end

  // Next state: bubbles clear valid but never overwrite held payload.
  always_comb begin
    v_d = v_q;
    p_d = p_q;
    if (in_r) v_d = in_v;
    if (in_r & in_v) p_d = shifted;
  end

  // Stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= 1'b0;
      p_q <= '0;
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  assign out_v = v_q;
  assign out_p = p_q;

endmodule

// File: rtl/base_shift_right_pipe.sv
// Pipelined right shifter: one amount bit per stage, largest weight first.
// width must be in [2, MAX_W].
module base_shift_right_pipe
  import base_shift_pkg::*;
#(
  parameter int width  = 32,
  parameter int swidth = $clog2(width)
) (
  input logic                    clk,
  input logic                    reset,
  base_shift_right_pipe_if.slave bus
);

  logic [swidth:0] vld_pipe;
  logic [swidth:0] rdy;
  stage_t          entry;
  stage_t          pay [1:swidth];

  // Build the entry payload; sign is captured here once (i_d[0] is the MSB).
  always_comb begin
    entry                    = '0;
    entry.data[width-1:0]    = bus.i_d;
    entry.amt[swidth-1:0]    = bus.i_samt;
    entry.arith              = bus.i_arith;
    entry.sign               = bus.i_d[0];
  end

  assign vld_pipe[0] = bus.i_v;
  assign rdy[swidth] = bus.o_r;

  for (genvar k = 0; k < swidth; k++) begin : g_stage
    stage_t in_p;
    if (k == 0) begin : g_first
      assign in_p = entry;
    end else begin : g_rest
      assign in_p = pay[k];
    end
    base_shift_right_stage #(
      .width  (width),
      .weight (1 << (swidth - 1 - k)),
      .amt_bit(swidth - 1 - k)
    ) u_stage (
      .clk  (clk),
      .reset(reset),
      .in_v (vld_pipe[k]),
      .in_r (rdy[k]),
      .in_p (in_p),
      .out_v(vld_pipe[k+1]),
      .out_r(rdy[k+1]),
      .out_p(pay[k+1])
    );
  end

  assign bus.i_r    = rdy[0];
  assign bus.o_v    = vld_pipe[swidth];
  assign bus.o_d    = pay[swidth].data[width-1:0];
  assign bus.o_lost = pay[swidth].lost;

endmodule

// File: tb/tb_base_shift_right_pipe.sv
// Bench for base_shift_right_pipe at width=8: directed vectors plus an
// in-order reference queue checked every cycle.
module tb_base_shift_right_pipe;
  localparam int W  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  base_shift_right_pipe_if #(.width(W), .swidth(SW)) bus ();

  base_shift_right_pipe #(.width(W), .swidth(SW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  typedef struct { logic [7:0] d; logic lost; } exp_t;
  exp_t q[$];

  bit mon_en = 0;
  bit tp_arm = 0;
  int tp_acc = -1, tp_first = -1, tp_last = -1, tp_cnt = 0;
  int n_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer shift semantics, lost = any 1 in the dropped low bits.
  function automatic exp_t model(input logic [7:0] d, input logic [2:0] a, input logic ar);
    exp_t r;
    r.d    = ar ? 8'($signed(d) >>> a) : (d >> a);
    r.lost = |(d & ((8'd1 << a) - 8'd1));
    return r;
  endfunction

  // Compare process: ready rule, output hold, in-order results.
  initial begin
    bit         stall_prev = 0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    logic [7:0] od;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        stall_prev = 0;
      end else if (mon_en) begin
        od = bus.o_d;
        chk("i_r_rule", {31'b0, bus.i_r}, {31'b0, !(q.size() == 3 && !bus.o_r)});
        if (stall_prev) begin
          chk("hold_v", {31'b0, bus.o_v}, 32'd1);
          chk("hold_d", {24'b0, od}, {24'b0, prev_d});
          chk("hold_lost", {31'b0, bus.o_lost}, {31'b0, prev_l});
        end
        if (bus.o_v && bus.o_r) begin
          if (q.size() == 0) begin
            chk("spurious_o_v", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("o_d", {24'b0, od}, {24'b0, e.d});
            chk("o_lost", {31'b0, bus.o_lost}, {31'b0, e.lost});
          end
          n_pop++;
          if (tp_arm) begin
            tp_cnt++;
            if (tp_first < 0) tp_first = cyc;
            tp_last = cyc;
          end
        end
        if (bus.i_v && bus.i_r) begin
          q.push_back(model(bus.i_d, bus.i_samt, bus.i_arith));
          if (tp_arm && tp_acc < 0) tp_acc = cyc;
        end
        stall_prev = bus.o_v && !bus.o_r;
        prev_d = od;
        prev_l = bus.o_lost;
      end
    end
  end

  // Single item through an empty pipe: latency and literal result.
  task automatic send_one(input logic [7:0] d, input logic [2:0] a, input logic ar,
                          input logic [7:0] xd, input logic xl, input string nm);
    int lat;
    bus.o_r = 1'b1;
    @(posedge clk); #1;
    bus.i_v = 1'b1; bus.i_d = d; bus.i_samt = a; bus.i_arith = ar;
    @(posedge clk); #1;
    bus.i_v = 1'b0;
    lat = 1;
    while (!bus.o_v && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_d"}, {24'b0, bus.o_d}, {24'b0, xd});
    chk({nm, "_lost"}, {31'b0, bus.o_lost}, {31'b0, xl});
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, guard, pops0;
    bit have;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, guard, pops0;
    bit  have;
    reset = 1'b1;
    bus.i_v = 1'b0; bus.o_r = 1'b0; bus.i_d = '0; bus.i_samt = '0; bus.i_arith = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_o_v", {31'b0, bus.o_v}, 32'd0);
    chk("rst_o_d", {24'b0, bus.o_d}, 32'd0);
    chk("rst_o_lost", {31'b0, bus.o_lost}, 32'd0);
    chk("rst_i_r", {31'b0, bus.i_r}, 32'd1);
    mon_en = 1;

    // Directed vectors with hand-computed results.
    send_one(8'b1011_0110, 3'd3, 1'b0, 8'b0001_0110, 1'b1, "log3");
    send_one(8'b1000_0000, 3'd7, 1'b1, 8'hFF, 1'b0, "ari7");
    send_one(8'b1000_0000, 3'd7, 1'b0, 8'h01, 1'b0, "log7");
    send_one(8'hA5, 3'd0, 1'b0, 8'hA5, 1'b0, "zero");
    send_one(8'h7F, 3'd5, 1'b1, 8'h03, 1'b1, "ari_pos");
    send_one(8'hC3, 3'd4, 1'b1, 8'hFC, 1'b1, "ari4");

    // Backpressure: 10 items, random o_r and i_v.
    sent = 0; guard = 0; have = 0;
    while (sent < 10 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
      bus.o_r = 1'($urandom);
      if (!have) begin
        bus.i_d = 8'($urandom); bus.i_samt = 3'($urandom); bus.i_arith = 1'($urandom);
        have = 1;
      end
      bus.i_v = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.i_v && bus.i_r) begin have = 0; sent++; end
    end
    chk("bp_sent", sent, 10);
    @(posedge clk); #1;
    bus.i_v = 1'b0; bus.o_r = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("bp_drained", q.size(), 0);

    // Full throughput: 20 back-to-back items.
    tp_arm = 1;
    for (int i = 0; i < 20; i++) begin
      bus.i_v = 1'b1; bus.i_d = 8'($urandom); bus.i_samt = 3'(i); bus.i_arith = 1'(i >> 3);
      @(posedge clk); #1;
    end
    bus.i_v = 1'b0;
    repeat (6) @(posedge clk);
    #1 tp_arm = 0;
    chk("tp_count", tp_cnt, 20);
    chk("tp_consecutive", tp_last - tp_first, 19);
    chk("tp_latency", tp_first - tp_acc, 3);

    // Reset mid-stream with a full, stalled pipe.
    bus.o_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_v = 1'b1; bus.i_d = 8'h11 * 8'(i + 1); bus.i_samt = 3'd1; bus.i_arith = 1'b0;
      @(posedge clk); #1;
    end
    chk("full_i_r", {31'b0, bus.i_r}, 32'd0);
    chk("full_o_v", {31'b0, bus.o_v}, 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.i_v = 1'b0;
    chk("mid_rst_o_v", {31'b0, bus.o_v}, 32'd0);
    chk("mid_rst_i_r", {31'b0, bus.i_r}, 32'd1);
    chk("mid_rst_o_d", {24'b0, bus.o_d}, 32'd0);
    pops0 = n_pop;
    bus.o_r = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("no_stale", n_pop - pops0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
